// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: stage state encoding,
// the MIPS NOP word and the default datapath width.
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } stage_state_e;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;  // sll $0,$0,0

  localparam int unsigned DefaultWidth = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and a clear that wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer,
// so in_ready depends only on registered state. Flush squashes the stage to NOP.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefaultWidth,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] NOP_VAL   = WIDTH'(MIPS_NOP),
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (in_fire) state_d = StOne;
        StOne: begin
          if (in_fire && !out_fire) begin
            state_d = StTwo;
          end else if (!in_fire && out_fire) begin
            state_d = StEmpty;
          end
        end
        StTwo:   if (out_fire) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != StEmpty);
    in_ready  = (state_q != StTwo);
  end

  // A beat accepted during flush is consumed by the handshake and dropped here.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = NOP_VAL;
      skid_d = NOP_VAL;
    end else begin
      unique case (state_q)
        StEmpty: if (in_fire) main_d = in;
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in;
          end else if (in_fire) begin
            skid_d = in;
          end
        end
        StTwo:   if (out_fire) main_d = skid_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out = main_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clr_cnt),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios then random traffic, all checked
// against a queue-based model of the stage.
module tb_pipe_skid_reg;

  localparam int unsigned Width = 32;
  localparam int unsigned CntW  = 4;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready, clr_cnt;
  logic [Width-1:0] din, dout;
  logic [CntW-1:0]  stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: held beats in acceptance order, last value on out, stall count.
  logic [31:0] m_q[$];
  logic [31:0] m_out;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH    (Width),
    .RESET_VAL(32'h0),
    .NOP_VAL  (32'h0),
    .CNT_W    (CntW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (dout),
    .clr_cnt  (clr_cnt),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then compare.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] d, input logic ordy, input logic clr);
    logic m_ov, m_ir, in_fire, out_fire;
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    din       = d;
    out_ready = ordy;
    clr_cnt   = clr;
    m_ov      = (m_q.size() > 0);
    m_ir      = (m_q.size() < 2);
    in_fire   = iv & m_ir;
    out_fire  = m_ov & ordy;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_out = 32'h0;
      m_cnt = 0;
    end else begin
      if (fl) begin
        m_q.delete();
        m_out = 32'h0;
      end else begin
        if (out_fire) m_out = m_q.pop_front();
        if (in_fire) m_q.push_back(d);
        if (m_q.size() > 0) m_out = m_q[0];
      end
      if (clr) begin
        m_cnt = 0;
      end else if (m_ov && !ordy && m_cnt < CntMax) begin
        m_cnt++;
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
    check("out", dout, m_out);
    check("stall_cnt", 32'(stall_cnt), m_cnt);
  endtask

  initial begin
    m_out = 32'h0;
    m_cnt = 0;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'hdead, 1'b1, 1'b1);  // in/flush/clr ignored in reset

    // Streaming
    cycle(1'b0, 1'b0, 1'b1, 32'd1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'd7, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'd6, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'd5, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Back-pressure then drain
    cycle(1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'd9, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Flush in TWO, with a beat offered in the flush cycle
    cycle(1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'd8, 1'b0, 1'b0);
    check("flush_out", dout, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Saturation and clear
    cycle(1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("sat_15", 32'(stall_cnt), 32'd15);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check("clr_0", 32'(stall_cnt), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("recount_1", 32'(stall_cnt), 32'd1);

    // Reset mid-stall in TWO
    cycle(1'b0, 1'b0, 1'b1, 32'd4, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Simultaneous accept and consume in ONE
    cycle(1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'd9, 1'b1, 1'b0);
    check("simul_out", dout, 32'd9);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(15) == 0),
            1'($urandom_range(1)), $urandom, 1'($urandom_range(3) != 0),
            ($urandom_range(15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating stall counter. It is the successor to the plain `Register` stage latch and sits between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Downstream back-pressure stalls the stage without losing data and without a combinational ready path to upstream. A hazard or branch flush squashes the stage to a NOP bubble.

## Interface
Parameters:
- `WIDTH`, 32: data width in bits.
- `RESET_VAL`, 0: value of the data registers after reset.
- `NOP_VAL`, 0: value of the data registers after flush (`32'h00000000` is the MIPS `sll $0,$0,0`).
- `CNT_W`, 16: stall counter width.

Ports:
- `clk` input, 1: the single clock; all state changes on its rising edge.
- `reset` input, 1: synchronous, active-high.
- `flush` input, 1: synchronous squash of stage contents.
- `in_valid` input, 1: upstream beat present.
- `in_ready` output, 1: stage can accept a beat; a function of registered state only.
- `in` input, WIDTH: upstream data.
- `out_valid` output, 1: `out` holds a valid beat.
- `out_ready` input, 1: downstream accepts.
- `out` output, WIDTH: stage data, driven directly from the main register.
- `clr_cnt` input, 1: clear the stall counter.
- `stall_cnt` output, CNT_W: number of back-pressured cycles.

## Operation
- Storage: `main` and `skid`, each WIDTH bits.
- States:
  - EMPTY: nothing held.
  - ONE: `main` valid.
  - TWO: `main` and `skid` valid.
- Handshake outputs: `out_valid` = (state != EMPTY); `in_ready` = (state != TWO).
- Handshake events: in_fire = `in_valid & in_ready`; out_fire = `out_valid & out_ready`.
- EMPTY:
  - in_fire: `main` <= `in`, go to ONE.
  - otherwise: hold.
- ONE:
  - in_fire and out_fire: `main` <= `in`, stay in ONE.
  - in_fire only: `skid` <= `in`, go to TWO.
  - out_fire only: go to EMPTY.
  - neither: hold.
- TWO (in_fire is impossible here):
  - out_fire: `main` <= `skid`, go to ONE.
  - otherwise: hold.
- Flush, priority below reset and above all handshake activity:
  - state <= EMPTY; `main` and `skid` <= NOP_VAL.
  - A beat that fires on `in` in the flush cycle is accepted by handshake and discarded.
  - An out_fire in the flush cycle completes normally from the downstream side.
- Stall counter:
  - Increments each cycle in which `out_valid & ~out_ready`.
  - Saturates at 2^CNT_W−1.
  - `reset` or `clr_cnt` clears it to 0; `clr_cnt` has priority over an increment in the same cycle.
  - Flush does not affect it.
- Data is never dropped or duplicated except by flush. Beats emerge in acceptance order.

## Timing
- Reset values (visible the cycle after `reset` is sampled high): state EMPTY, `out` = RESET_VAL, `out_valid` = 0, `in_ready` = 1, `stall_cnt` = 0.
- During the reset cycle, `in`, `flush` and `clr_cnt` are ignored.
- Latency: a beat accepted at edge N is presented on `out` with `out_valid` = 1 after edge N.
- Throughput: one beat per cycle while `out_ready` is held high.
- `in_ready` falls the cycle after the first back-pressured accept (ONE→TWO). It rises the cycle after out_fire in TWO.
- `out` keeps its last value when EMPTY; after a flush it reads NOP_VAL.
- Reset asserted mid-stall (state TWO) discards both entries; the next cycle behaves as post-reset.

## Structure
- Shared package `pipe_pkg`:
  - State encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - `MIPS_NOP` = 32'h00000000.
  - Default WIDTH.
- One natural sub-module: `sat_counter` (params `W`; ports `clk`, `reset`, `clr`, `inc`, `count`), instantiated for `stall_cnt`.
- The state machine and the two data registers live in `pipe_skid_reg`.

## Test plan
All scenarios use WIDTH=32, RESET_VAL=0, NOP_VAL=0, CNT_W=4.
- Streaming: `out_ready`=1; send 1, 7, 6, 5 on consecutive cycles → `out` shows 1, 7, 6, 5 one cycle later each; `in_ready` stays 1; `stall_cnt`=0.
- Back-pressure: `out_ready`=0; send 1, then 7 → `in_ready`=0 after the second accept, `out`=1 held. Raise `out_ready` → `out` reads 1 then 7; `in_ready` returns to 1.
- Flush in TWO: stage holds 1 and 7, assert `flush` → next cycle `out_valid`=0, `out`=0, `in_ready`=1; neither 1 nor 7 ever emerges.
- Saturation: hold a valid beat with `out_ready`=0 for 20 cycles → `stall_cnt` reaches 15 and stays at 15. Pulse `clr_cnt` → next cycle `stall_cnt`=0, then it counts again from 1.
- Reset mid-operation: in TWO with `stall_cnt`=3, assert `reset` → next cycle `out_valid`=0, `out`=0, `in_ready`=1, `stall_cnt`=0.
- Simultaneous: in ONE holding 5, with `in_valid` (9) and `out_ready` both high → 5 is consumed, `out`=9 next cycle, state stays ONE.
